button_debounce: RTL and testbench

- Filters one noisy, asynchronous push-button or sensor input into a clean debounced level, plus single-cycle press and release strobes.
- One instance sits in front of each operator button in the parking controller: entry and exit.
- Runs on the controller's slow system clock clk_1Hz, but is clock-rate agnostic.

---
 rtl/button_debounce.sv | 79 +++++++
 tb/tb_button_debounce.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/button_debounce.sv
// Button debouncer: two-flop synchronizer, stability counter,
// registered debounced level and single-cycle press/release strobes.
//
// Ports:
//   clk_1Hz        system clock, rising-edge active
//   reset_n        asynchronous active-low reset
//   button_in      raw asynchronous button/sensor level (active-high)
//   button_out     debounced level, registered
//   button_press   one-cycle strobe on button_out 0->1
//   button_release one-cycle strobe on button_out 1->0
`timescale 1ns/1ps

module button_debounce #(
    parameter int   STABLE_CYCLES = 2,
    parameter logic RESET_LEVEL   = 1'b0
) (
    input  logic clk_1Hz,
    input  logic reset_n,
    input  logic button_in,
    output logic button_out,
    output logic button_press,
    output logic button_release
);

    // Counter just wide enough to hold STABLE_CYCLES; at least one bit.
    localparam int CW =
        (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);

    localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

    logic          sync_ff1;
    logic          sync_ff2;
    logic [CW-1:0] counter;
    logic          differs;
    logic          done;

    // Synchronized sample disagrees with the current debounced level.
    assign differs = sync_ff2 ^ button_out;

    // This edge completes the stability window and flips the output.
    assign done = differs && (counter == LAST);

    always_ff @(posedge clk_1Hz or negedge reset_n) begin
        if (!reset_n) begin
            sync_ff1 <= RESET_LEVEL;
            sync_ff2 <= RESET_LEVEL;
        end else begin
            sync_ff1 <= button_in;
            sync_ff2 <= sync_ff1;
        end
    end

    always_ff @(posedge clk_1Hz or negedge reset_n) begin
        if (!reset_n) begin
            button_out     <= RESET_LEVEL;
            counter        <= '0;
            button_press   <= 1'b0;
            button_release <= 1'b0;
        end else begin
            // Strobes derive from the same decision that moves
            // button_out, so they align with its change and are
            // mutually exclusive.
            button_press   <= done &  sync_ff2;
            button_release <= done & ~sync_ff2;

            if (!differs) begin
                // Agreement discards any partial count, so short
                // glitches never accumulate.
                counter <= '0;
            end else if (done) begin
                button_out <= sync_ff2;
                counter    <= '0;
            end else begin
                counter <= counter + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce:
// reset, press, release, glitch rejection, async reset, param sweep.
`timescale 1ns/1ps

module tb_button_debounce;

    logic clk_1Hz;
    logic reset_n;
    logic button_in;
    logic button_out;
    logic button_press;
    logic button_release;

    logic b_sw;
    logic out1, press1, rel1;
    logic out5, press5, rel5;

    int checks;
    int errors;

    button_debounce #(.STABLE_CYCLES(2)) dut (
        .clk_1Hz        (clk_1Hz),
        .reset_n        (reset_n),
        .button_in      (button_in),
        .button_out     (button_out),
        .button_press   (button_press),
        .button_release (button_release)
    );

    button_debounce #(.STABLE_CYCLES(1)) u1 (
        .clk_1Hz        (clk_1Hz),
        .reset_n        (reset_n),
        .button_in      (b_sw),
        .button_out     (out1),
        .button_press   (press1),
        .button_release (rel1)
    );

    button_debounce #(.STABLE_CYCLES(5)) u5 (
        .clk_1Hz        (clk_1Hz),
        .reset_n        (reset_n),
        .button_in      (b_sw),
        .button_out     (out5),
        .button_press   (press5),
        .button_release (rel5)
    );

    initial clk_1Hz = 1'b0;
    always #5 clk_1Hz = ~clk_1Hz;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_1Hz);
        #1;
    endtask

    task automatic chk_main(input string tag, input logic o,
                            input logic p, input logic r);
        chk({tag, ".out"}, {7'd0, button_out}, {7'd0, o});
        chk({tag, ".press"}, {7'd0, button_press}, {7'd0, p});
        chk({tag, ".release"}, {7'd0, button_release}, {7'd0, r});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, errors %0d",
                 errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        reset_n   = 1'b0;
        button_in = 1'b1;
        b_sw      = 1'b0;

        // Reset held for 3 edges with button_in high.
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk_main($sformatf("rst_e%0d", k), 1'b0, 1'b0, 1'b0);
        end
        chk("rst_counter", {6'd0, dut.counter}, 8'd0);

        // Release reset between edges; press already present.
        reset_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk_main($sformatf("press_e%0d", k),
                     (k >= 4), (k == 4), 1'b0);
        end

        // Clean release.
        button_in = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk_main($sformatf("rel_e%0d", k),
                     (k < 4), 1'b0, (k == 4));
        end

        // One-sample glitches every 3 edges for 12 edges.
        for (int k = 1; k <= 12; k++) begin
            button_in = (k % 3 == 1);
            tick();
            chk_main($sformatf("glitch_e%0d", k), 1'b0, 1'b0, 1'b0);
        end
        button_in = 1'b0;
        tick();
        tick();
        chk("glitch_counter", {6'd0, dut.counter}, 8'd0);

        // Async reset while the counter is 1.
        button_in = 1'b1;
        tick();
        tick();
        tick();
        chk("mid_counter_pre", {6'd0, dut.counter}, 8'd1);
        chk_main("mid_pre", 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_counter_rst", {6'd0, dut.counter}, 8'd0);
        chk("mid_sync2_rst", {7'd0, dut.sync_ff2}, 8'd0);
        chk_main("mid_rst", 1'b0, 1'b0, 1'b0);
        #2;
        reset_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk_main($sformatf("restart_e%0d", k),
                     (k >= 4), (k == 4), 1'b0);
            if (k == 3)
                chk("restart_counter", {6'd0, dut.counter}, 8'd1);
        end

        // Parameter sweep: STABLE_CYCLES 1 and 5, steady press.
        b_sw = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("s1_out_e%0d", k), {7'd0, out1},
                {7'd0, (k >= 3)});
            chk($sformatf("s1_press_e%0d", k), {7'd0, press1},
                {7'd0, (k == 3)});
            chk($sformatf("s5_out_e%0d", k), {7'd0, out5},
                {7'd0, (k >= 7)});
            chk($sformatf("s5_press_e%0d", k), {7'd0, press5},
                {7'd0, (k == 7)});
            chk($sformatf("sw_rel_e%0d", k), {6'd0, rel1, rel5}, 8'd0);
            chk_main($sformatf("hold_e%0d", k), 1'b1, 1'b0, 1'b0);
        end

        // Sweep release: symmetric latency.
        b_sw = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("s1_rout_e%0d", k), {7'd0, out1},
                {7'd0, (k < 3)});
            chk($sformatf("s1_rel_e%0d", k), {6'd0, rel1, press1},
                {6'd0, (k == 3), 1'b0});
            chk($sformatf("s5_rout_e%0d", k), {7'd0, out5},
                {7'd0, (k < 7)});
            chk($sformatf("s5_rel_e%0d", k), {6'd0, rel5, press5},
                {6'd0, (k == 7), 1'b0});
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
